// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic matrix-multiply engine.
// Contents: FSM state enum, run-length function, saturating add helper.
// The saturating add is used by systolic_pe only when SYSTOLIC_SAT_EN is defined.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } systolicState_t;

    // Result of a saturating add; value is wide enough for any ACCW up to 63.
    typedef struct packed {
        logic               clipped;
        logic signed [63:0] value;
    } satResult_t;

    // Number of MAC steps for one run: the last PE sees its last operand at K+ROWS+COLS-3.
    function automatic int unsigned calcSteps(input int unsigned rows,
                                              input int unsigned cols,
                                              input int unsigned k);
        return k + rows + cols - 2;
    endfunction

    // Adds two sign-extended operands and clips the sum to a signed w-bit range.
    function automatic satResult_t satAdd(input logic signed [63:0] a,
                                          input logic signed [63:0] b,
                                          input int unsigned        w);
        satResult_t         res;
        logic signed [63:0] sum;
        logic signed [63:0] maxV;
        logic signed [63:0] minV;
        sum         = a + b;
        maxV        = (64'sd1 <<< (w - 1)) - 64'sd1;
        minV        = -(64'sd1 <<< (w - 1));
        res.clipped = 1'b0;
        res.value   = sum;
        if (sum > maxV) begin
            res.clipped = 1'b1;
            res.value   = maxV;
        end else if (sum < minV) begin
            res.clipped = 1'b1;
            res.value   = minV;
        end
        return res;
    endfunction

endpackage

// File: rtl/systolic_pe.sv
// One systolic processing element: multiplies the operands arriving from the
// left (a) and top (b), accumulates into an ACCW register, and forwards both
// operands one cycle later to the right and downward neighbours.
// Ports: load clears the forwarding regs (and acc when accClear) at run accept;
// en performs one MAC step; clip_c flags a clipped update this cycle.
// Macro SYSTOLIC_SAT_EN: saturating accumulation; otherwise wrap modulo 2^ACCW.
module systolic_pe
    import systolic_pkg::*;
#(
    parameter int unsigned BW   = 8,
    parameter int unsigned ACCW = 19
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            load,
    input  logic            accClear,
    input  logic            en,
    input  logic [BW-1:0]   aLeft,
    input  logic [BW-1:0]   bTop,
    output logic [BW-1:0]   aRight,
    output logic [BW-1:0]   bDown,
    output logic [ACCW-1:0] acc,
    output logic            clip_c
);

    logic signed [2*BW-1:0] prod;
    logic signed [ACCW-1:0] prodExt;
    logic [ACCW-1:0]        accNext;

    // Full-precision signed product, sign-extended to the accumulator width.
    assign prod    = (2*BW)'($signed(aLeft)) * (2*BW)'($signed(bTop));
    assign prodExt = ACCW'(prod);

`ifdef SYSTOLIC_SAT_EN
    satResult_t sum;

    always_comb begin
        sum = satAdd(64'($signed(acc)), 64'(prodExt), ACCW);
    end

    assign accNext = ACCW'(sum.value);
    assign clip_c  = sum.clipped;
`else
    assign accNext = acc + $unsigned(prodExt);
    assign clip_c  = 1'b0;
`endif

    // Operand pipeline and accumulator.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aRight <= '0;
            bDown  <= '0;
            acc    <= '0;
        end else if (load) begin
            aRight <= '0;
            bDown  <= '0;
            if (accClear) begin
                acc <= '0;
            end
        end else if (en) begin
            aRight <= aLeft;
            bDown  <= bTop;
            acc    <= accNext;
        end
    end

endmodule

// File: rtl/systolic_matmul_engine.sv
// Self-sequencing systolic matrix multiply: oRes = A(ROWSxK) * B(KxCOLS), signed.
// Ports: iStart/iAccum request a run (accepted in IDLE or DONE) and latch iA/iB;
// oBusy is high during RUN, oDone pulses for one cycle when oRes is final;
// oRes comes straight from the PE accumulators; oSat reports clipping in the last run.
// Macro SYSTOLIC_SAT_EN: saturating accumulation with sticky oSat; otherwise oSat stays 0.
module systolic_matmul_engine
    import systolic_pkg::*;
#(
    parameter int unsigned BW   = 8,
    parameter int unsigned ROWS = 5,
    parameter int unsigned COLS = 5,
    parameter int unsigned K    = 5,
    parameter int unsigned ACCW = 2 * BW + $clog2(K)
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 iStart,
    input  logic                                 iAccum,
    input  logic [0:ROWS-1][0:K-1][BW-1:0]       iA,
    input  logic [0:K-1][0:COLS-1][BW-1:0]       iB,
    output logic                                 oBusy,
    output logic                                 oDone,
    output logic [0:ROWS-1][0:COLS-1][ACCW-1:0]  oRes,
    output logic                                 oSat
);

    localparam int unsigned L    = calcSteps(ROWS, COLS, K);
    localparam int unsigned CNTW = $clog2(L + 1);

    systolicState_t                      state;
    systolicState_t                      stateNext;
    logic [CNTW-1:0]                     stepCnt;
    logic                                accept;
    logic                                stepEn;
    logic                                busyNext;
    logic                                doneNext;
    logic [0:ROWS-1][0:K-1][BW-1:0]      aCap;
    logic [0:K-1][0:COLS-1][BW-1:0]      bCap;
    logic [ROWS-1:0][BW-1:0]             aFeed;
    logic [COLS-1:0][BW-1:0]             bFeed;
    logic [ROWS-1:0][COLS-1:0][BW-1:0]   aLink;
    logic [ROWS-1:0][COLS-1:0][BW-1:0]   bLink;
    logic [ROWS*COLS-1:0]                clipVec;
    logic [ROWS-1:0]                     unusedA;
    logic [COLS-1:0]                     unusedB;

    assign stepEn = (state == RUN);

    // Next state, run accept and registered status flags.
    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                if (iStart) begin
                    accept    = 1'b1;
                    stateNext = RUN;
                end
            end
            RUN: begin
                if (stepCnt == CNTW'(L - 1)) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                if (iStart) begin
                    accept    = 1'b1;
                    stateNext = RUN;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
        busyNext = (stateNext == RUN);
        doneNext = (stateNext == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            oBusy   <= 1'b0;
            oDone   <= 1'b0;
            oSat    <= 1'b0;
            stepCnt <= '0;
            aCap    <= '0;
            bCap    <= '0;
        end else begin
            state <= stateNext;
            oBusy <= busyNext;
            oDone <= doneNext;
            if (accept) begin
                aCap    <= iA;
                bCap    <= iB;
                stepCnt <= '0;
                oSat    <= 1'b0;
            end else if (stepEn) begin
                stepCnt <= stepCnt + CNTW'(1);
                oSat    <= oSat | (|clipVec);
            end
        end
    end

    // Skew feeder: row r sees a[r][s-r], column c sees b[s-c][c]; out of range is a zero bubble.
    always_comb begin
        aFeed = '0;
        bFeed = '0;
        for (int r = 0; r < int'(ROWS); r++) begin
            for (int k = 0; k < int'(K); k++) begin
                if (int'(stepCnt) == k + r) begin
                    aFeed[r] = aCap[r][k];
                end
            end
        end
        for (int c = 0; c < int'(COLS); c++) begin
            for (int k = 0; k < int'(K); k++) begin
                if (int'(stepCnt) == k + c) begin
                    bFeed[c] = bCap[k][c];
                end
            end
        end
    end

    // PE grid: a flows right along a row, b flows down a column.
    for (genvar r = 0; r < ROWS; r++) begin : gRow
        for (genvar c = 0; c < COLS; c++) begin : gCol
            logic [BW-1:0] aIn;
            logic [BW-1:0] bIn;

            if (c == 0) begin : gLeftEdge
                assign aIn = aFeed[r];
            end else begin : gLeftLink
                assign aIn = aLink[r][c-1];
            end

            if (r == 0) begin : gTopEdge
                assign bIn = bFeed[c];
            end else begin : gTopLink
                assign bIn = bLink[r-1][c];
            end

            systolic_pe #(
                .BW  (BW),
                .ACCW(ACCW)
            ) uPe (
                .clk     (clk),
                .rst_n   (rst_n),
                .load    (accept),
                .accClear(~iAccum),
                .en      (stepEn),
                .aLeft   (aIn),
                .bTop    (bIn),
                .aRight  (aLink[r][c]),
                .bDown   (bLink[r][c]),
                .acc     (oRes[r][c]),
                .clip_c  (clipVec[r*COLS+c])
            );
        end
        // Operands leaving the right edge have no consumer.
        assign unusedA[r] = ^aLink[r][COLS-1];
    end

    // Operands leaving the bottom edge have no consumer.
    for (genvar c = 0; c < COLS; c++) begin : gBottom
        assign unusedB[c] = ^bLink[ROWS-1][c];
    end

endmodule

// File: tb/tb_systolic_matmul_engine.sv
// Directed self-checking bench for systolic_matmul_engine.
// Three instances: 5x5x5 default, 2x3x4 rectangular, and 5x5x5 with ACCW=16
// for the overflow case (expectations follow SYSTOLIC_SAT_EN).
module tb_systolic_matmul_engine;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance 0: 5x5x5, ACCW = 19
    logic                       start0, accum0, oBusy0, oDone0, oSat0;
    logic [0:4][0:4][7:0]       iA0, iB0;
    logic [0:4][0:4][18:0]      oRes0;
    // Instance 1: ROWS=2, COLS=3, K=4, ACCW = 18
    logic                       start1, accum1, oBusy1, oDone1, oSat1;
    logic [0:1][0:3][7:0]       iA1;
    logic [0:3][0:2][7:0]       iB1;
    logic [0:1][0:2][17:0]      oRes1;
    // Instance 2: 5x5x5, ACCW = 16
    logic                       start2, accum2, oBusy2, oDone2, oSat2;
    logic [0:4][0:4][7:0]       iA2, iB2;
    logic [0:4][0:4][15:0]      oRes2;

    systolic_matmul_engine u0 (
        .clk(clk), .rst_n(rst_n), .iStart(start0), .iAccum(accum0),
        .iA(iA0), .iB(iB0), .oBusy(oBusy0), .oDone(oDone0), .oRes(oRes0), .oSat(oSat0)
    );

    systolic_matmul_engine #(.BW(8), .ROWS(2), .COLS(3), .K(4)) u1 (
        .clk(clk), .rst_n(rst_n), .iStart(start1), .iAccum(accum1),
        .iA(iA1), .iB(iB1), .oBusy(oBusy1), .oDone(oDone1), .oRes(oRes1), .oSat(oSat1)
    );

    systolic_matmul_engine #(.BW(8), .ROWS(5), .COLS(5), .K(5), .ACCW(16)) u2 (
        .clk(clk), .rst_n(rst_n), .iStart(start2), .iAccum(accum2),
        .iA(iA2), .iB(iB2), .oBusy(oBusy2), .oDone(oDone2), .oRes(oRes2), .oSat(oSat2)
    );

    // A = identity, B[k][c] = k*5+c on instance 0.
    task automatic loadIdentity();
        for (int r = 0; r < 5; r++) begin
            for (int k = 0; k < 5; k++) begin
                iA0[r][k] = (r == k) ? 8'd1 : 8'd0;
                iB0[r][k] = 8'(r * 5 + k);
            end
        end
    endtask

    // Starts one run on instance 0 and returns the edge count to oDone (-1 on timeout).
    task automatic run0(input logic accum, output int doneEdge, output int busyCycles);
        @(negedge clk);
        start0 = 1'b1;
        accum0 = accum;
        @(posedge clk);
        #1;
        start0     = 1'b0;
        busyCycles = oBusy0 ? 1 : 0;
        doneEdge   = -1;
        for (int n = 1; n <= 40 && doneEdge < 0; n++) begin
            @(posedge clk);
            #1;
            if (oBusy0) busyCycles++;
            if (oDone0) doneEdge = n;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2;
        rst_n = 1'b0;
        #2;
        checks++;
        if (oBusy0 !== 1'b0 || oDone0 !== 1'b0 || oSat0 !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b done=%b sat=%b, required 0 0 0", oBusy0, oDone0, oSat0);
        end
        checks++;
        if (oRes0 !== '0 || oRes1 !== '0 || oRes2 !== '0) begin
            errors++;
            $display("FAIL reset_res: results not all zero");
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_identity();
        int doneEdge, busyCycles;
        loadIdentity();
        run0(1'b0, doneEdge, busyCycles);
        checks++;
        if (doneEdge != 13) begin
            errors++;
            $display("FAIL ident_latency: done at edge %0d, required 13", doneEdge);
        end
        checks++;
        if (busyCycles != 13) begin
            errors++;
            $display("FAIL ident_busy: busy for %0d cycles, required 13", busyCycles);
        end
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                checks++;
                if (oRes0[r][c] !== 19'(r * 5 + c)) begin
                    errors++;
                    $display("FAIL ident_res[%0d][%0d]: got %0d, required %0d", r, c, oRes0[r][c], r * 5 + c);
                end
            end
        end
        checks++;
        if (oSat0 !== 1'b0) begin
            errors++;
            $display("FAIL ident_sat: got %b, required 0", oSat0);
        end
        @(posedge clk);
        #1;
        checks++;
        if (oDone0 !== 1'b0 || oBusy0 !== 1'b0) begin
            errors++;
            $display("FAIL ident_done_width: done=%b busy=%b one cycle after done, required 0 0", oDone0, oBusy0);
        end
        checks++;
        if (oRes0[4][4] !== 19'd24) begin
            errors++;
            $display("FAIL ident_hold: res[4][4]=%0d in idle, required 24", oRes0[4][4]);
        end
    endtask

    task automatic test_accumulate();
        int doneEdge, busyCycles;
        run0(1'b1, doneEdge, busyCycles);
        checks++;
        if (doneEdge != 13) begin
            errors++;
            $display("FAIL accum_latency: done at edge %0d, required 13", doneEdge);
        end
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                checks++;
                if (oRes0[r][c] !== 19'(2 * (r * 5 + c))) begin
                    errors++;
                    $display("FAIL accum_res[%0d][%0d]: got %0d, required %0d", r, c, oRes0[r][c], 2 * (r * 5 + c));
                end
            end
        end
        run0(1'b0, doneEdge, busyCycles);
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                checks++;
                if (oRes0[r][c] !== 19'(r * 5 + c)) begin
                    errors++;
                    $display("FAIL clear_res[%0d][%0d]: got %0d, required %0d", r, c, oRes0[r][c], r * 5 + c);
                end
            end
        end
    endtask

    task automatic test_rect();
        int doneEdge;
        for (int k = 0; k < 4; k++) begin
            iA1[0][k] = 8'(k + 1);
            iA1[1][k] = 8'(-(k + 1));
            for (int c = 0; c < 3; c++) iB1[k][c] = 8'd1;
        end
        @(negedge clk);
        start1 = 1'b1;
        accum1 = 1'b0;
        @(posedge clk);
        #1;
        start1   = 1'b0;
        doneEdge = -1;
        for (int n = 1; n <= 30 && doneEdge < 0; n++) begin
            @(posedge clk);
            #1;
            if (oDone1) doneEdge = n;
        end
        checks++;
        if (doneEdge != 7) begin
            errors++;
            $display("FAIL rect_latency: done at edge %0d, required 7", doneEdge);
        end
        for (int r = 0; r < 2; r++) begin
            for (int c = 0; c < 3; c++) begin
                checks++;
                if (oRes1[r][c] !== 18'((r == 0) ? 10 : -10)) begin
                    errors++;
                    $display("FAIL rect_res[%0d][%0d]: got %0d, required %0d", r, c,
                             $signed(oRes1[r][c]), (r == 0) ? 10 : -10);
                end
            end
        end
    endtask

    task automatic test_saturation();
        int doneEdge;
        logic [15:0] expRes;
        logic        expSat;
`ifdef SYSTOLIC_SAT_EN
        expRes = 16'd32767;
        expSat = 1'b1;
`else
        expRes = 16'd16384;
        expSat = 1'b0;
`endif
        iA2 = {25{8'h80}};
        iB2 = {25{8'h80}};
        @(negedge clk);
        start2 = 1'b1;
        accum2 = 1'b0;
        @(posedge clk);
        #1;
        start2   = 1'b0;
        doneEdge = -1;
        for (int n = 1; n <= 30 && doneEdge < 0; n++) begin
            @(posedge clk);
            #1;
            if (oDone2) doneEdge = n;
        end
        checks++;
        if (doneEdge != 13) begin
            errors++;
            $display("FAIL sat_latency: done at edge %0d, required 13", doneEdge);
        end
        checks++;
        if (oRes2[0][0] !== expRes || oRes2[2][3] !== expRes || oRes2[4][4] !== expRes) begin
            errors++;
            $display("FAIL sat_res: got %0d %0d %0d, required %0d", oRes2[0][0], oRes2[2][3], oRes2[4][4], expRes);
        end
        checks++;
        if (oSat2 !== expSat) begin
            errors++;
            $display("FAIL sat_flag: got %b, required %b", oSat2, expSat);
        end
        // A small follow-up run clears the sticky flag.
        iA2 = {25{8'h01}};
        iB2 = {25{8'h01}};
        @(negedge clk);
        start2 = 1'b1;
        @(posedge clk);
        #1;
        start2   = 1'b0;
        doneEdge = -1;
        for (int n = 1; n <= 30 && doneEdge < 0; n++) begin
            @(posedge clk);
            #1;
            if (oDone2) doneEdge = n;
        end
        checks++;
        if (doneEdge != 13 || oRes2[3][1] !== 16'd5 || oSat2 !== 1'b0) begin
            errors++;
            $display("FAIL sat_clear: done edge %0d res %0d sat %b, required 13 5 0", doneEdge, oRes2[3][1], oSat2);
        end
    endtask

    task automatic test_back_to_back();
        int doneCount, firstDone, doneEdge;
        loadIdentity();
        @(negedge clk);
        start0 = 1'b1;
        accum0 = 1'b0;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        // Operands change after accept; the run uses the captured copy.
        iB0 = {25{8'd7}};
        doneCount = 0;
        firstDone = -1;
        for (int n = 1; n <= 13; n++) begin
            start0 = (n == 5);
            @(posedge clk);
            #1;
            if (oDone0) begin
                doneCount++;
                firstDone = n;
            end
        end
        checks++;
        if (doneCount != 1 || firstDone != 13) begin
            errors++;
            $display("FAIL ignore_start: %0d done pulses, last at edge %0d, required 1 at 13", doneCount, firstDone);
        end
        checks++;
        if (oRes0[3][2] !== 19'd17 || oRes0[0][4] !== 19'd4) begin
            errors++;
            $display("FAIL capture_res: got %0d %0d, required 17 4", oRes0[3][2], oRes0[0][4]);
        end
        start0 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        checks++;
        if (oBusy0 !== 1'b1 || oDone0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: busy=%b done=%b after restart edge, required 1 0", oBusy0, oDone0);
        end
        doneEdge = -1;
        for (int n = 1; n <= 30 && doneEdge < 0; n++) begin
            @(posedge clk);
            #1;
            if (oDone0) doneEdge = n;
        end
        checks++;
        if (doneEdge != 13) begin
            errors++;
            $display("FAIL b2b_latency: done at edge %0d, required 13", doneEdge);
        end
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                checks++;
                if (oRes0[r][c] !== 19'd7) begin
                    errors++;
                    $display("FAIL b2b_res[%0d][%0d]: got %0d, required 7", r, c, oRes0[r][c]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        int  doneEdge, busyCycles;
        logic sawDone;
        loadIdentity();
        @(negedge clk);
        start0 = 1'b1;
        accum0 = 1'b0;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (oBusy0 !== 1'b0 || oDone0 !== 1'b0 || oSat0 !== 1'b0) begin
            errors++;
            $display("FAIL midrst_ctrl: busy=%b done=%b sat=%b, required 0 0 0", oBusy0, oDone0, oSat0);
        end
        checks++;
        if (oRes0 !== '0) begin
            errors++;
            $display("FAIL midrst_res: res[0][1]=%0d res[4][4]=%0d, required all zero", oRes0[0][1], oRes0[4][4]);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        sawDone = 1'b0;
        repeat (16) begin
            @(posedge clk);
            #1;
            if (oDone0 || oBusy0) sawDone = 1'b1;
        end
        checks++;
        if (sawDone !== 1'b0) begin
            errors++;
            $display("FAIL midrst_nodone: activity seen after reset, required none");
        end
        // Accumulate onto the cleared state: a fresh run yields plain B.
        run0(1'b1, doneEdge, busyCycles);
        checks++;
        if (doneEdge != 13) begin
            errors++;
            $display("FAIL restart_latency: done at edge %0d, required 13", doneEdge);
        end
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 5; c++) begin
                checks++;
                if (oRes0[r][c] !== 19'(r * 5 + c)) begin
                    errors++;
                    $display("FAIL restart_res[%0d][%0d]: got %0d, required %0d", r, c, oRes0[r][c], r * 5 + c);
                end
            end
        end
    endtask

    initial begin
        start0 = 1'b0; accum0 = 1'b0; iA0 = '0; iB0 = '0;
        start1 = 1'b0; accum1 = 1'b0; iA1 = '0; iB1 = '0;
        start2 = 1'b0; accum2 = 1'b0; iA2 = '0; iB2 = '0;
        test_reset();
        test_identity();
        test_accumulate();
        test_rect();
        test_saturation();
        test_back_to_back();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic_matmul_engine.md
# systolic_matmul_engine

Parametrised, self-sequencing systolic matrix-multiply engine. It computes the ROWS×COLS result of an ROWS×K by K×COLS product of signed operands. A start/busy/done handshake, operand skewing, the PE grid and completion timing are all contained in one block. It supersedes the fixed square N×N array-plus-feeder wrapper and adds rectangular shapes, an accumulate mode, handshake-based back-to-back runs and optional saturation.

## Interface
- BW, 8, operand width (signed two's complement)
- ROWS, 5, rows of A and of the result
- COLS, 5, columns of B and of the result
- K, 5, inner dimension (columns of A, rows of B)
- ACCW, 2*BW+$clog2(K), accumulator/result width (signed)
- clk  input  1  clock, rising-edge
- rst_n  input  1  reset, asynchronous, active-low
- iStart  input  1  run request; sampled on rising edge
- iAccum  input  1  sampled with accepted iStart: 1 = add onto existing results, 0 = clear first
- iA  input  [BW-1:0][0:ROWS-1][0:K-1]  operand A; captured on accept
- iB  input  [BW-1:0][0:K-1][0:COLS-1]  operand B; captured on accept
- oBusy  output  1  high while in RUN
- oDone  output  1  one-cycle pulse; oRes final
- oRes  output  [ACCW-1:0][0:ROWS-1][0:COLS-1]  registered result matrix
- oSat  output  1  saturation occurred in the last run (see Configuration)

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Accept: iStart=1 on an edge while in IDLE or DONE.
  - That edge latches iA, iB and iAccum.
  - If iAccum=0, all accumulators clear to 0. oSat clears.
  - Step counter is set to 0 and the state goes to RUN.
- iStart in RUN is ignored: no queuing and no effect on the run in progress.
- RUN: one MAC step per edge. Step s = 0..L-1, where L = K+ROWS+COLS-2.
  - PE(r,c) adds a[r][k]*b[k][c] at step s = k+r+c.
  - Skewed inputs outside 0≤k<K are zero bubbles and contribute nothing.
- At the edge that performs step L-1, the state goes to DONE.
- DONE lasts exactly one cycle, with oDone=1. The next edge goes to IDLE, or back to RUN if iStart=1 (back-to-back runs).
- Products are full 2*BW signed, sign-extended to ACCW before accumulation.
- oRes is driven directly from the accumulator registers.
  - It holds its value in IDLE and DONE.
  - Mid-RUN values are partial sums and are not guaranteed.

## Timing
- Reset values: oBusy=0, oDone=0, oSat=0, every oRes element 0, state IDLE, counter 0.
- Accept edge E0. MAC edges E1..EL. oBusy=1 from E0 to EL. oDone=1 from EL to EL+1.
- Accept-to-done latency is L edges. Example: for ROWS=COLS=K=5, L=13.
- Back-to-back: iStart asserted during DONE gives oDone, then oBusy=1 on the next cycle. There is zero idle gap.
- rst_n asserted mid-RUN: immediate return to reset values, with no oDone pulse. The first accept after reset behaves as a fresh run.
- iA and iB may change freely after the accept edge.

## Configuration
- SYSTOLIC_SAT_EN defined:
  - Each accumulator update saturates to [-2^(ACCW-1), 2^(ACCW-1)-1].
  - Any clipping sets oSat. oSat is sticky until the next accept.
- SYSTOLIC_SAT_EN undefined:
  - Accumulation wraps modulo 2^ACCW.
  - oSat is tied to 0.
- Port list is identical in both builds.

## Structure
- Package systolic_pkg holds:
  - the state enum typedef (IDLE/RUN/DONE);
  - a function computing L from ROWS/COLS/K;
  - the saturating-add function used under SYSTOLIC_SAT_EN.
- Sub-module systolic_pe: one processing element containing:
  - a-reg forwarded right and b-reg forwarded down;
  - multiplier and ACCW accumulator;
  - clear/accumulate enable and saturation flag.
- The engine instantiates ROWS×COLS systolic_pe in a generate loop. The skew/bubble feeder and FSM live in the top module.

## Test plan
- 5×5×5, A=identity, B[k][c]=k*5+c, iAccum=0 → accept, oDone exactly 13 edges later, oRes=B, oBusy high 13 cycles.
- ROWS=2, COLS=3, K=4, A=[[1,2,3,4],[-1,-2,-3,-4]], B all 1 → oDone at edge 7. Row 0 results = 10, row 1 results = -10.
- Same 5×5 run twice, second run with iAccum=1 → oRes doubles (2*B). A third run with iAccum=0 restores B.
- BW=8, K=5, ACCW=16, all operands -128:
  - SYSTOLIC_SAT_EN defined → every oRes = 32767, oSat=1.
  - SYSTOLIC_SAT_EN undefined → 81920 mod 65536 = 16384, oSat=0.
- iStart pulsed at edge E5 of a run → ignored, single oDone. iStart held during DONE → second run starts with no gap, second oDone 13 edges later.
- rst_n low at edge E6 of a 5×5 run → all outputs 0 asynchronously, no oDone. Restart after release gives the correct result.
